// File: rtl/sonar_echo_detector.sv
// -----------------------------------------------------------------------------
// sonar_echo_detector
//
// Takes the signed Q15 FIR output, rectifies it and smooths it into an unsigned
// envelope. A ping-triggered state machine uses that envelope to report either
// a time-of-flight (samples from start to the first threshold crossing) or a
// timeout.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   en            sample strobe (same strobe as the FIR)
//   y_in          signed FIR output, held stable between strobes
//   start         one-cycle ping trigger, restarts a measurement in any state
//   blank         samples after start during which echoes are ignored
//   timeout       sample count that ends a measurement with no echo (0 = max)
//   thr_hi        detect threshold on env
//   thr_lo        release threshold on env (hysteresis)
//   env           registered unsigned envelope
//   tof           captured count at detection, all-ones on timeout
//   valid         one-cycle pulse, tof updated by a detection
//   timeout_flag  one-cycle pulse, measurement ended without echo
//   busy          high while a measurement is in progress (BLANK/LISTEN/HOLD)
// -----------------------------------------------------------------------------
module sonar_echo_detector #(
   parameter int N  = 16,
   parameter int CW = 16,
   parameter int K  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic signed [N-1:0] y_in,
   input  logic                start,
   input  logic [CW-1:0]       blank,
   input  logic [CW-1:0]       timeout,
   input  logic [N-1:0]        thr_hi,
   input  logic [N-1:0]        thr_lo,
   output logic [N-1:0]        env,
   output logic [CW-1:0]       tof,
   output logic                valid,
   output logic                timeout_flag,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BLANK  = 2'd1,
      S_LISTEN = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] t_eff;
   logic [N-1:0]  env_nxt;
   logic          detect;
   logic          expire;

   // Magnitude of a signed sample; the most negative code has no positive
   // counterpart and is clamped to the largest positive value.
   function automatic logic [N-1:0] rectify(input logic signed [N-1:0] x);
      logic [N-1:0] mag;
      if (x == {1'b1, {(N-1){1'b0}}})
         mag = {1'b0, {(N-1){1'b1}}};
      else if (x[N-1])
         mag = ~x + 1'b1;
      else
         mag = x;
      return mag;
   endfunction

   // One-pole smoother: acc + (mag - acc) * 2^-K. The difference is carried
   // at N+1 bits so its sign survives, and the arithmetic shift floors toward
   // minus infinity, which lets the envelope decay all the way to zero. Both
   // operands are below 2^(N-1), so the sum never leaves that range.
   function automatic logic [N-1:0] smooth(input logic [N-1:0] acc,
                                           input logic [N-1:0] mag);
      logic signed [N:0] diff;
      logic signed [N:0] step;
      diff = $signed({1'b0, mag}) - $signed({1'b0, acc});
      step = diff >>> K;
      return acc + step[N-1:0];
   endfunction

   assign busy    = (state != S_IDLE);
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   assign t_eff   = (timeout == '0) ? '1 : timeout;
   assign env_nxt = smooth(env, rectify(y_in));

   // Next-state decisions use the count and envelope as they will be after
   // this strobe. The sample on which cnt reaches blank is already a listening
   // sample, so BLANK falls through to the LISTEN check on that strobe.
   always_comb begin
      state_nxt = state;
      detect    = 1'b0;
      expire    = 1'b0;
      if (start) begin
         state_nxt = S_BLANK;
      end else if (en) begin
         case (state)
            S_IDLE: state_nxt = S_IDLE;
            S_BLANK, S_LISTEN: begin
               if (cnt_inc >= t_eff) begin
                  expire    = 1'b1;
                  state_nxt = S_IDLE;
               end else if ((state == S_LISTEN) || (cnt_inc >= blank)) begin
                  if (env_nxt >= thr_hi) begin
                     detect    = 1'b1;
                     state_nxt = S_HOLD;
                  end else begin
                     state_nxt = S_LISTEN;
                  end
               end
            end
            S_HOLD: begin
               if (env_nxt < thr_lo)
                  state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         env          <= '0;
         tof          <= '0;
         valid        <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         valid        <= detect;
         timeout_flag <= expire;
         if (en)
            env <= env_nxt;
         if (start)
            cnt <= '0;
         else if (en && busy)
            cnt <= cnt_inc;
         if (detect)
            tof <= cnt_inc;
         else if (expire)
            tof <= '1;
      end
   end

endmodule
